rtc_edit_fsm: RTL and testbench
===============================

// Module: rtc_edit_fsm
// PURPOSE
//  User-edit controller for the RTC: date (dia/mes/year), clock (fhh/fhm/fhs) and timer (th/tm/ts) fields, all BCD.
//  Successor to the first user-config FSM: calendar-aware day limits with leap years, 12/24 h with PM flag, edge-detected buttons.
//  Also adds inactivity timeout and one-cycle commit strobes to the RTC write path.
//  Sits between the debounced button/switch inputs and the RTC register-write interface.
// PARAMETERS
//  ENTRY_A     3'b010  pstate value that permits entering edit
//  ENTRY_B     3'b100  second pstate value that permits entering edit
//  TIMEOUT_CYC 0       idle cycles in an edit state before auto-exit; 0 = timeout disabled
//  TO_W        32      width of timeout/repeat counter
//  RPT_DELAY   50_000_000  cycles a held up/dw waits before auto-repeat (macro only)
//  RPT_PERIOD  10_000_000  cycles between repeats after the delay (macro only)
// PORTS
//  clk      in  1  system clock
//  rst      in  1  synchronous active-high reset
//  up,dw    in  1  increment/decrement field (debounced level)
//  lf,rg    in  1  previous/next field (debounced level)
//  prom     in  1  exit edit and commit
//  swfh,swt in  1  select clock/date group, or timer group
//  formato  in  1  1 = 24 h, 0 = 12 h; sampled in TIPO only
//  pstate   in  3  RTC master-FSM state
//  sta      out 4  current state code
//  dia,mes,year,fhh,fhm,fhs,th,tm,ts  out 8 each  BCD field values
//  fmt24    out 1  latched hour format
//  pm       out 1  PM flag; 12 h mode only, forced 0 in 24 h
//  wr_clk   out 1  one-cycle strobe: commit date/clock fields
//  wr_tmr   out 1  one-cycle strobe: commit timer fields
// BEHAVIOUR
//  Reset: sta=HOLD; dia=01, mes=01; all other fields 00; fmt24=1, pm=0, wr_*=0, counters 0.
//  Buttons are rising-edge detected against a registered copy; the field updates on the clk edge that samples the new-high level.
//  State codes: HOLD 0, FHT 1, TIPO 2, RESETR 3, RDIA 4, RMES 5, RYEAR 6, RHORA 7, RMIN 8, RSEG 9, RESETT A, THORA B, TMIN C, TSEG D.
//  Unused codes go to HOLD.
//  HOLD->FHT when pstate==ENTRY_A|ENTRY_B and prom=0.
//  FHT: swfh&~swt->TIPO; swt&~swfh->RESETT; otherwise->HOLD.
//  TIPO: fmt24<=formato, pm<=0, ->RESETR.
//  RESETR: loads dia=01, mes=01, year/fhh/fhm/fhs=00, ->RDIA.
//  RESETT: loads th/tm/ts=00, ->THORA.
//  Clock ring (rg forward, lf back, wraps): RDIA-RMES-RYEAR-RHORA-RMIN-RSEG.
//  Timer ring: THORA-TMIN-TSEG. Groups never cross.
//  Priority in edit states: prom > navigation > edit.
//  prom in clock ring: ->HOLD and wr_clk=1 for 1 cycle; in timer ring: wr_tmr=1 instead.
//  lf&rg both rising, or up&dw both rising: that pair is ignored for the cycle.
//  Field ranges (BCD, all wrap both directions):
//   - dia 01..dmax; dmax = 31/30, Feb = 29 if year%4==0 else 28.
//   - mes 01..12; year 00..99; minutes and seconds 00..59.
//   - fhh 00..23 (24 h) or 01..12 (12 h); th 00..23.
//  12 h mode: pm toggles on 11->12 (up) and 12->11 (down).
//  Every write to mes or year clamps dia to the new dmax in the same cycle.
//  All BCD arithmetic is digit-correct: low nibble 9->0 carries, 0->9 borrows; no non-BCD value is ever produced.
//  Timeout (TIMEOUT_CYC>0): counter clears on any button edge or state change.
//  On reaching TIMEOUT_CYC the FSM exits to HOLD with the same wr_* strobe as prom.
//  rst mid-edit: immediate return to reset values; no strobe is emitted.
// CONFIGURATION
//  RTC_EDIT_AUTOREPEAT_EN defined:
//   - up/dw held RPT_DELAY cycles issues one extra step, then one step every RPT_PERIOD cycles while held.
//   - Releasing the button, or holding both, stops repeat.
//  RTC_EDIT_AUTOREPEAT_EN undefined: exactly one step per rising edge; RPT_* parameters are unused.
// TESTING
//  rst; pstate=010, prom=0, swfh=1, formato=1 -> sta 0,1,2,3,4; dia=01, mes=01, fmt24=1.
//  RDIA, dia=31, up edge -> dia=01; dw edge -> dia=31; 09 up -> 10; 10 dw -> 09.
//  dia=31, go to RMES, mes 01->02 with year=23 -> dia=28; with year=24 -> dia=29.
//  12 h: fhh=11, pm=0, up -> fhh=12, pm=1; up -> fhh=01, pm=1; 24 h: fhh=23 up -> 00.
//  Timer ring: THORA, lf -> TSEG; rg -> THORA; prom -> HOLD, wr_tmr high exactly 1 cycle, wr_clk=0.
//  TIMEOUT_CYC=100, idle in RMIN 100 cycles -> HOLD with wr_clk pulse; rst during RMIN -> HOLD, fields reset, no strobe.

Source files
------------

// File: rtl/rtc_edit_fsm_if.sv
// rtc_edit_fsm_if: button/switch inputs and BCD field/commit outputs of the RTC edit controller
interface rtc_edit_fsm_if;
    logic       up, dw, lf, rg, prom, swfh, swt, formato;
    logic [2:0] pstate;
    logic [3:0] sta;
    logic [7:0] dia, mes, year, fhh, fhm, fhs, th, tm, ts;
    logic       fmt24, pm, wr_clk, wr_tmr;
    modport master (
        output up, dw, lf, rg, prom, swfh, swt, formato, pstate,
        input  sta, dia, mes, year, fhh, fhm, fhs, th, tm, ts, fmt24, pm, wr_clk, wr_tmr
    );
    modport slave (
        input  up, dw, lf, rg, prom, swfh, swt, formato, pstate,
        output sta, dia, mes, year, fhh, fhm, fhs, th, tm, ts, fmt24, pm, wr_clk, wr_tmr
    );
endinterface

// File: rtl/rtc_edit_fsm.sv
// rtc_edit_fsm: BCD date/clock/timer edit FSM; define RTC_EDIT_AUTOREPEAT_EN for held up/dw auto-repeat
module rtc_edit_fsm #(
    parameter logic [2:0] ENTRY_A     = 3'b010,
    parameter logic [2:0] ENTRY_B     = 3'b100,
    parameter int         TIMEOUT_CYC = 0,
    parameter int         TO_W        = 32,
    parameter int         RPT_DELAY   = 50_000_000,
    parameter int         RPT_PERIOD  = 10_000_000
) (
    input logic          clk,
    input logic          rst,
    rtc_edit_fsm_if.slave b
);
    typedef enum logic [3:0] {
        HOLD = 4'h0, FHT, TIPO, RESETR, RDIA, RMES, RYEAR, RHORA, RMIN, RSEG, RESETT, THORA, TMIN, TSEG
    } state_t;
    typedef struct packed {
        logic [7:0] dia, mes, year, fhh, fhm, fhs, th, tm, ts;
        logic       fmt24, pm;
    } regs_t;
    localparam regs_t RST_REGS = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

    function automatic logic [6:0] bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction
    function automatic logic [7:0] bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction
    // Stepping in binary and converting back keeps every result a legal BCD value.
    function automatic logic [7:0] step(input logic [7:0] v, input logic [6:0] lo, input logic [6:0] hi, input logic inc);
        logic [6:0] x;
        x = bin(v);
        return bcd(inc ? (x >= hi ? lo : x + 7'd1) : (x <= lo ? hi : x - 7'd1));
    endfunction
    function automatic logic [6:0] dmax(input logic [7:0] m, input logic [7:0] y);
        logic [6:0] mb;
        mb = bin(m);
        return mb == 7'd2 ? (bin(y) % 7'd4 == 7'd0 ? 7'd29 : 7'd28) :
               (mb == 7'd4 || mb == 7'd6 || mb == 7'd9 || mb == 7'd11) ? 7'd30 : 7'd31;
    endfunction
    function automatic logic [7:0] clamp(input logic [7:0] d, input logic [6:0] mx);
        return bin(d) > mx ? bcd(mx) : d;
    endfunction

    state_t          st, nx;
    regs_t           r, rn;
    logic            wr_c, wr_t, wr_c_n, wr_t_n;
    logic [3:0]      btn_q, e;
    logic [TO_W-1:0] to_cnt;
    logic            clk_ring, tmr_ring, edit, inc, dec, go_l, go_r, to_hit, edge_any, rpt_up, rpt_dw;

    assign e        = {b.up, b.dw, b.lf, b.rg} & ~btn_q;
    assign inc      = (e[3] && !e[2]) || rpt_up;
    assign dec      = (e[2] && !e[3]) || rpt_dw;
    assign go_l     = e[1] && !e[0];
    assign go_r     = e[0] && !e[1];
    assign edge_any = |e || rpt_up || rpt_dw;
    assign clk_ring = st >= RDIA && st <= RSEG;
    assign tmr_ring = st >= THORA && st <= TSEG;
    assign edit     = clk_ring || tmr_ring;
    assign to_hit   = TIMEOUT_CYC != 0 && to_cnt == TO_W'(TIMEOUT_CYC - 1);

`ifdef RTC_EDIT_AUTOREPEAT_EN
    logic [TO_W-1:0] rpt_cnt;
    logic            rpt_on, held, rpt_fire;
    // Only a single button already high last cycle counts as held; the edge cycle steps on its own.
    assign held     = edit && (b.up ^ b.dw) && (b.up ? btn_q[3] : btn_q[2]);
    assign rpt_fire = held && rpt_cnt == (rpt_on ? TO_W'(RPT_PERIOD - 1) : TO_W'(RPT_DELAY - 1));
    assign rpt_up   = rpt_fire && b.up;
    assign rpt_dw   = rpt_fire && b.dw;
    always_ff @(posedge clk) begin
        if (rst || !held) begin
            rpt_cnt <= '0;
            rpt_on  <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt <= '0;
            rpt_on  <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + TO_W'(1);
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
    assign rpt_up     = 1'b0;
    assign rpt_dw     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        btn_q <= {b.up, b.dw, b.lf, b.rg};
        if (rst) begin
            st     <= HOLD;
            r      <= RST_REGS;
            wr_c   <= 1'b0;
            wr_t   <= 1'b0;
            to_cnt <= '0;
        end else begin
            st     <= nx;
            r      <= rn;
            wr_c   <= wr_c_n;
            wr_t   <= wr_t_n;
            to_cnt <= (nx != st || edge_any || !edit) ? '0 : to_cnt + TO_W'(1);
        end
    end

    always_comb begin
        nx     = st;
        rn     = r;
        wr_c_n = 1'b0;
        wr_t_n = 1'b0;
        case (st)
            HOLD:   nx = ((b.pstate == ENTRY_A || b.pstate == ENTRY_B) && !b.prom) ? FHT : HOLD;
            FHT:    nx = (b.swfh && !b.swt) ? TIPO : (b.swt && !b.swfh) ? RESETT : HOLD;
            TIPO: begin
                rn.fmt24 = b.formato;
                rn.pm    = 1'b0;
                nx       = RESETR;
            end
            RESETR: begin
                rn.dia  = 8'h01;
                rn.mes  = 8'h01;
                rn.year = 8'h00;
                rn.fhh  = 8'h00;
                rn.fhm  = 8'h00;
                rn.fhs  = 8'h00;
                nx      = RDIA;
            end
            RESETT: begin
                rn.th = 8'h00;
                rn.tm = 8'h00;
                rn.ts = 8'h00;
                nx    = THORA;
            end
            RDIA, RMES, RYEAR, RHORA, RMIN, RSEG, THORA, TMIN, TSEG: begin
                if (b.prom || to_hit) begin
                    nx     = HOLD;
                    wr_c_n = clk_ring;
                    wr_t_n = tmr_ring;
                end else if (go_r) begin
                    nx = st == RSEG ? RDIA : st == TSEG ? THORA : state_t'(st + 4'd1);
                end else if (go_l) begin
                    nx = st == RDIA ? RSEG : st == THORA ? TSEG : state_t'(st - 4'd1);
                end else if (inc || dec) begin
                    case (st)
                        RDIA:  rn.dia = step(r.dia, 7'd1, dmax(r.mes, r.year), inc);
                        RMES: begin
                            rn.mes = step(r.mes, 7'd1, 7'd12, inc);
                            rn.dia = clamp(r.dia, dmax(rn.mes, r.year));
                        end
                        RYEAR: begin
                            rn.year = step(r.year, 7'd0, 7'd99, inc);
                            rn.dia  = clamp(r.dia, dmax(r.mes, rn.year));
                        end
                        RHORA: begin
                            rn.fhh = r.fmt24 ? step(r.fhh, 7'd0, 7'd23, inc) : step(r.fhh, 7'd1, 7'd12, inc);
                            rn.pm  = (!r.fmt24 && (inc ? r.fhh == 8'h11 : r.fhh == 8'h12)) ? !r.pm : r.pm;
                        end
                        RMIN:  rn.fhm = step(r.fhm, 7'd0, 7'd59, inc);
                        RSEG:  rn.fhs = step(r.fhs, 7'd0, 7'd59, inc);
                        THORA: rn.th  = step(r.th, 7'd0, 7'd23, inc);
                        TMIN:  rn.tm  = step(r.tm, 7'd0, 7'd59, inc);
                        TSEG:  rn.ts  = step(r.ts, 7'd0, 7'd59, inc);
                        default: ;
                    endcase
                end
            end
            default: nx = HOLD;
        endcase
    end

    assign b.sta    = st;
    assign b.dia    = r.dia;
    assign b.mes    = r.mes;
    assign b.year   = r.year;
    assign b.fhh    = r.fhh;
    assign b.fhm    = r.fhm;
    assign b.fhs    = r.fhs;
    assign b.th     = r.th;
    assign b.tm     = r.tm;
    assign b.ts     = r.ts;
    assign b.fmt24  = r.fmt24;
    assign b.pm     = r.pm;
    assign b.wr_clk = wr_c;
    assign b.wr_tmr = wr_t;
endmodule

// File: tb/tb_rtc_edit_fsm.sv
// tb_rtc_edit_fsm: scoreboard bench with a field-level calendar/clock model for rtc_edit_fsm
module tb_rtc_edit_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    rtc_edit_fsm_if bus ();
    rtc_edit_fsm #(.TIMEOUT_CYC(100)) dut (.clk(clk), .rst(rst), .b(bus.slave));
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sta;
        logic [7:0] dia, mes, year, fhh, fhm, fhs, th, tm, ts;
        logic       fmt24, pm;
    } snap_t;
    typedef struct {
        int    tag;
        snap_t s;
        string name;
    } exp_t;

    exp_t  q[$];
    int    sq_tag[$];
    int    sq_kind[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_tag;
    snap_t ds;
    exp_t  ex;
    string names[7] = '{"up", "dw", "lf", "rg", "updw", "lfrg", "prom"};
    int    pick[10] = '{0, 0, 0, 1, 1, 1, 2, 3, 4, 5};

    // model: state code plus plain binary field values
    int m_st, md, mm, my, hh, mi, se, th, tm, ts;
    bit fmt, pm;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int days(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        return (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
    endfunction
    function automatic int wrap(int v, int lo, int hi, bit u);
        return u ? (v >= hi ? lo : v + 1) : (v <= lo ? hi : v - 1);
    endfunction
    function automatic int bcd(int v);
        return (v / 10) * 16 + v % 10;
    endfunction
    function automatic snap_t model_snap();
        return {4'(m_st), 8'(bcd(md)), 8'(bcd(mm)), 8'(bcd(my)), 8'(bcd(hh)), 8'(bcd(mi)), 8'(bcd(se)),
                8'(bcd(th)), 8'(bcd(tm)), 8'(bcd(ts)), fmt, pm};
    endfunction

    task automatic model_reset();
        m_st = 0; md = 1; mm = 1; my = 0; hh = 0; mi = 0; se = 0; th = 0; tm = 0; ts = 0; fmt = 1; pm = 0;
    endtask
    task automatic expect_at(input int tag, input string name);
        q.push_back('{tag, model_snap(), name});
    endtask

    task automatic edit_field(input bit u);
        case (m_st)
            4: md = wrap(md, 1, days(mm, my), u);
            5: begin mm = wrap(mm, 1, 12, u); if (md > days(mm, my)) md = days(mm, my); end
            6: begin my = wrap(my, 0, 99, u); if (md > days(mm, my)) md = days(mm, my); end
            7: if (fmt) hh = wrap(hh, 0, 23, u);
               else begin
                   if ((u && hh == 11) || (!u && hh == 12)) pm = !pm;
                   hh = wrap(hh, 1, 12, u);
               end
            8: mi = wrap(mi, 0, 59, u);
            9: se = wrap(se, 0, 59, u);
            11: th = wrap(th, 0, 23, u);
            12: tm = wrap(tm, 0, 59, u);
            13: ts = wrap(ts, 0, 59, u);
            default: ;
        endcase
    endtask

    task automatic apply(input int k);
        bit cr, tr;
        cr = m_st >= 4 && m_st <= 9;
        tr = m_st >= 11 && m_st <= 13;
        if (!(cr || tr)) return;
        case (k)
            0, 1: edit_field(k == 0);
            2: m_st = cr ? 4 + (m_st - 4 + 5) % 6 : 11 + (m_st - 11 + 2) % 3;
            3: m_st = cr ? 4 + (m_st - 3) % 6 : 11 + (m_st - 10) % 3;
            6: begin
                sq_tag.push_back(cyc + 1);
                sq_kind.push_back(cr ? 1 : 2);
                m_st = 0;
            end
            default: ;
        endcase
    endtask

    task automatic press(input int k);
        @(negedge clk);
        bus.up = (k == 0 || k == 4);
        bus.dw = (k == 1 || k == 4);
        bus.lf = (k == 2 || k == 5);
        bus.rg = (k == 3 || k == 5);
        bus.prom = (k == 6);
        bus.formato = 1'($urandom_range(0, 1));
        apply(k);
        last_tag = cyc + 1;
        expect_at(last_tag, names[k]);
        @(negedge clk);
        {bus.up, bus.dw, bus.lf, bus.rg, bus.prom} = '0;
        expect_at(cyc + 1, {"release_", names[k]});
    endtask

    task automatic enter(input bit fh, input bit t, input bit f, input bit alt);
        @(negedge clk);
        bus.pstate = alt ? 3'b100 : 3'b010;
        bus.swfh = fh;
        bus.swt = t;
        bus.formato = f;
        m_st = 1;
        expect_at(cyc + 1, "fht");
        @(negedge clk);
        bus.pstate = 3'b000;
        if (fh && !t) begin
            m_st = 2;
            expect_at(cyc + 1, "tipo");
            @(negedge clk);
            fmt = f; pm = 0; m_st = 3;
            expect_at(cyc + 1, "resetr");
            @(negedge clk);
            md = 1; mm = 1; my = 0; hh = 0; mi = 0; se = 0; m_st = 4;
            expect_at(cyc + 1, "rdia");
        end else if (t && !fh) begin
            m_st = 10;
            expect_at(cyc + 1, "resett");
            @(negedge clk);
            th = 0; tm = 0; ts = 0; m_st = 11;
            expect_at(cyc + 1, "thora");
        end else begin
            m_st = 0;
            expect_at(cyc + 1, "fht_exit");
        end
    endtask

    always @(posedge clk) begin
        #1;
        ds = {bus.sta, bus.dia, bus.mes, bus.year, bus.fhh, bus.fhm, bus.fhs, bus.th, bus.tm, bus.ts, bus.fmt24, bus.pm};
        while (q.size() > 0 && q[0].tag <= cyc) begin
            ex = q.pop_front();
            checks++;
            if (ex.tag != cyc || ds !== ex.s) begin
                errors++;
                $display("FAIL %s cyc=%0d tag=%0d got=%h expected=%h", ex.name, cyc, ex.tag, ds, ex.s);
            end
        end
        if (bus.wr_clk || bus.wr_tmr) begin
            checks++;
            if (sq_tag.size() == 0) begin
                errors++;
                $display("FAIL strobe cyc=%0d got kind=%0d expected none", cyc, {bus.wr_tmr, bus.wr_clk});
            end else begin
                if (sq_tag[0] != cyc || sq_kind[0] != int'({bus.wr_tmr, bus.wr_clk})) begin
                    errors++;
                    $display("FAIL strobe cyc=%0d got kind=%0d expected kind=%0d at %0d",
                             cyc, {bus.wr_tmr, bus.wr_clk}, sq_kind[0], sq_tag[0]);
                end
                void'(sq_tag.pop_front());
                void'(sq_kind.pop_front());
            end
        end
        while (sq_tag.size() > 0 && sq_tag[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL strobe_missing cyc=%0d got none expected kind=%0d at %0d", cyc, sq_kind[0], sq_tag[0]);
            void'(sq_tag.pop_front());
            void'(sq_kind.pop_front());
        end
    end

    initial begin
        {bus.up, bus.dw, bus.lf, bus.rg, bus.prom, bus.swfh, bus.swt} = '0;
        bus.formato = 1'b1;
        bus.pstate = 3'b000;
        model_reset();
        repeat (3) @(negedge clk);
        expect_at(cyc + 1, "reset");
        @(negedge clk);
        rst = 1'b0;
        expect_at(cyc + 1, "idle_hold");
        // group select edge cases and both entry codes
        enter(1'b1, 1'b1, 1'b1, 1'b0);
        enter(1'b0, 1'b0, 1'b1, 1'b1);
        // directed calendar checks in 12 h mode
        enter(1'b1, 1'b0, 1'b0, 1'b0);
        press(1); press(0);
        repeat (8) press(0);
        press(0); press(1);
        press(3); press(3);
        repeat (23) press(0);
        press(2); press(2);
        while (md != 31) press(0);
        press(3); press(0);
        press(3); press(0);
        press(2); press(1);
        press(2);
        while (md != 31) press(0);
        press(3); press(0);
        press(3); press(3);
        while (hh != 11) press(0);
        press(0); press(0);
        press(6);
        // 24 h wrap
        enter(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) press(3);
        press(1); press(0);
        press(6);
        // timer ring navigation and commit
        enter(1'b0, 1'b1, 1'b0, 1'b0);
        press(2); press(3);
        press(6);
        // randomized editing in both groups
        for (int n = 0; n < 4; n++) begin
            enter(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 60; i++) press(pick[$urandom_range(0, 9)]);
            press(6);
        end
        for (int n = 0; n < 2; n++) begin
            enter(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 40; i++) press(pick[$urandom_range(0, 9)]);
            press(6);
        end
        // inactivity timeout in RMIN
        enter(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) press(3);
        expect_at(last_tag + 99, "timeout_wait");
        m_st = 0;
        expect_at(last_tag + 100, "timeout_exit");
        sq_tag.push_back(last_tag + 100);
        sq_kind.push_back(1);
        repeat (110) @(negedge clk);
        // reset mid-edit: no strobe, fields back to reset values
        enter(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) press(0);
        repeat (4) press(3);
        press(0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        expect_at(cyc + 1, "rst_mid_edit");
        @(negedge clk);
        rst = 1'b0;
        expect_at(cyc + 1, "after_rst");
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expect got %0d left expected 0", q.size());
        end
        checks++;
        if (sq_tag.size() != 0) begin
            errors++;
            $display("FAIL pending_strobe got %0d left expected 0", sq_tag.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
